// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared types and constants for the 2x2 request crossbar.
// Holds the slave-port FSM encoding, master/slave ids and the grant picker.
package crossbar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FWD  = 2'b01,
      ST_RESP = 2'b10
   } xbar_state_t;

   localparam logic SLV0 = 1'b0;
   localparam logic SLV1 = 1'b1;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int SEL_BIT_DEF = 31;

   // Winner among candidate masters; ptr names the favoured one
   // and only matters when both are candidates.
   function automatic logic rr_pick(
      input logic [1:0] cand,
      input logic       ptr
   );
      if (cand == 2'b11) return ptr ? M1 : M0;
      return cand[1] ? M1 : M0;
   endfunction

endpackage

// File: rtl/xbar_slave_port.sv
// xbar_slave_port: one slave-side port of the crossbar.
// Masks and arbitrates master requests (round-robin), owns the
// IDLE/FWD/RESP handshake with the slave and forwards the granted
// master's bus.
// Ports:
//   clk, reset          clock, async active-low reset
//   m_req, m_cmd        per-master request / write flag
//   m0_addr, m1_addr    master addresses
//   m0_wdata, m1_wdata  master write data
//   m_ack               registered master acks (mask during pulse)
//   s_req .. s_wdata    slave-side request bus
//   s_ack               slave ack
//   ack_done            one-cycle completion (RESP and ack low)
//   grant_id            master currently owning this port
module xbar_slave_port
   import crossbar_pkg::*;
#(
   parameter int   DATA_W  = 32,
   parameter int   ADDR_W  = 32,
   parameter int   SEL_BIT = SEL_BIT_DEF,
   parameter logic IDX     = SLV0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        m_req,
   input  logic [1:0]        m_cmd,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [1:0]        m_ack,
   output logic              s_req,
   output logic              s_cmd,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic              s_ack,
   output logic              ack_done,
   output logic              grant_id
);

   xbar_state_t state_q;
   logic        ptr_q;
   logic        gid_q;
   logic        req_q;
   logic [1:0]  hit;
   logic [1:0]  cand;
   logic        sel_m1;

   assign hit[0] = (m0_addr[SEL_BIT] == IDX);
   assign hit[1] = (m1_addr[SEL_BIT] == IDX);

   // A master in its ack cycle is masked so a held req
   // is not re-granted on top of its own completion.
   assign cand = m_req & hit & ~m_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= M0;
         gid_q   <= M0;
         req_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (|cand) begin
                  gid_q   <= rr_pick(cand, ptr_q);
                  req_q   <= 1'b1;
                  state_q <= ST_FWD;
               end
            end
            ST_FWD: begin
               if (s_ack) begin
                  req_q   <= 1'b0;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (!s_ack) begin
                  ptr_q   <= ~gid_q;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Idle bus follows master 0; busy bus follows the grant.
   assign sel_m1 = (state_q != ST_IDLE) && (gid_q == M1);

   assign s_req   = req_q;
   assign s_cmd   = sel_m1 ? m_cmd[1]  : m_cmd[0];
   assign s_addr  = sel_m1 ? m1_addr   : m0_addr;
   assign s_wdata = sel_m1 ? m1_wdata  : m0_wdata;

   assign ack_done = (state_q == ST_RESP) && !s_ack;
   assign grant_id = gid_q;

endmodule

// File: rtl/crossbar_2x2.sv
// crossbar_2x2: two-master / two-slave request router.
// Address bit SEL_BIT picks the slave; each slave port arbitrates
// round-robin and the top turns completions into registered acks/rdata.
// Ports:
//   clk, reset              clock, async active-low reset
//   mN_req/cmd/addr/wdata   master request bus (N = 0,1)
//   mN_ack, mN_rdata        registered completion pulse and data
//   sK_req/cmd/addr/wdata   slave request bus (K = 0,1)
//   sK_ack, sK_rdata        slave response
module crossbar_2x2
   import crossbar_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int SEL_BIT = SEL_BIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_cmd,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_cmd,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s0_req,
   output logic              s0_cmd,
   output logic [ADDR_W-1:0] s0_addr,
   output logic [DATA_W-1:0] s0_wdata,
   input  logic              s0_ack,
   input  logic [DATA_W-1:0] s0_rdata,
   output logic              s1_req,
   output logic              s1_cmd,
   output logic [ADDR_W-1:0] s1_addr,
   output logic [DATA_W-1:0] s1_wdata,
   input  logic              s1_ack,
   input  logic [DATA_W-1:0] s1_rdata
);

   logic [1:0] m_req;
   logic [1:0] m_cmd;
   logic [1:0] m_ack;
   logic [1:0] p_done;
   logic [1:0] p_gid;
   logic       p0_m0;
   logic       p0_m1;
   logic       p1_m0;
   logic       p1_m1;

   assign m_req = {m1_req, m0_req};
   assign m_cmd = {m1_cmd, m0_cmd};
   assign m_ack = {m1_ack, m0_ack};

   xbar_slave_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .SEL_BIT (SEL_BIT),
      .IDX     (SLV0)
   ) u_port0 (
      .clk      (clk),
      .reset    (reset),
      .m_req    (m_req),
      .m_cmd    (m_cmd),
      .m0_addr  (m0_addr),
      .m1_addr  (m1_addr),
      .m0_wdata (m0_wdata),
      .m1_wdata (m1_wdata),
      .m_ack    (m_ack),
      .s_req    (s0_req),
      .s_cmd    (s0_cmd),
      .s_addr   (s0_addr),
      .s_wdata  (s0_wdata),
      .s_ack    (s0_ack),
      .ack_done (p_done[0]),
      .grant_id (p_gid[0])
   );

   xbar_slave_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .SEL_BIT (SEL_BIT),
      .IDX     (SLV1)
   ) u_port1 (
      .clk      (clk),
      .reset    (reset),
      .m_req    (m_req),
      .m_cmd    (m_cmd),
      .m0_addr  (m0_addr),
      .m1_addr  (m1_addr),
      .m0_wdata (m0_wdata),
      .m1_wdata (m1_wdata),
      .m_ack    (m_ack),
      .s_req    (s1_req),
      .s_cmd    (s1_cmd),
      .s_addr   (s1_addr),
      .s_wdata  (s1_wdata),
      .s_ack    (s1_ack),
      .ack_done (p_done[1]),
      .grant_id (p_gid[1])
   );

   // Completion of port K on behalf of master N.
   assign p0_m0 = p_done[0] && (p_gid[0] == M0);
   assign p0_m1 = p_done[0] && (p_gid[0] == M1);
   assign p1_m0 = p_done[1] && (p_gid[1] == M0);
   assign p1_m1 = p_done[1] && (p_gid[1] == M1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         m0_ack <= p0_m0 || p1_m0;
         m1_ack <= p0_m1 || p1_m1;
         if (p0_m0)      m0_rdata <= s0_rdata;
         else if (p1_m0) m0_rdata <= s1_rdata;
         if (p0_m1)      m1_rdata <= s0_rdata;
         else if (p1_m1) m1_rdata <= s1_rdata;
      end
   end

endmodule

// File: tb/tb_crossbar_2x2.sv
// tb_crossbar_2x2: directed bench for crossbar_2x2 with slave models
// and a per-master rdata scoreboard.
module tb_crossbar_2x2;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_cmd, m1_req, m1_cmd;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s0_req, s0_cmd, s1_req, s1_cmd;
   logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
   logic        s0_ack, s1_ack;
   logic [31:0] s0_rdata, s1_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp0[$];
   logic [31:0] exp1[$];

   logic [31:0] tr_s0, tr_s1, tr_a0, tr_a1;
   int lim0, lim1, acks0, acks1;
   int fwd1_n, fwd1_bad;

   always #5 clk = ~clk;

   crossbar_2x2 dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .s0_req(s0_req), .s0_cmd(s0_cmd), .s0_addr(s0_addr),
      .s0_wdata(s0_wdata), .s0_ack(s0_ack), .s0_rdata(s0_rdata),
      .s1_req(s1_req), .s1_cmd(s1_cmd), .s1_addr(s1_addr),
      .s1_wdata(s1_wdata), .s1_ack(s1_ack), .s1_rdata(s1_rdata)
   );

   // Slave model: ack after two req cycles, ack high two cycles,
   // rdata = transaction count, valid from the second ack cycle.
   for (genvar g = 0; g < 2; g++) begin : g_slv
      logic        req;
      logic        ack;
      logic [31:0] rd;
      logic [31:0] cnt;
      int          ph;
      int          wc;
      assign req = (g == 0) ? s0_req : s1_req;
      always @(posedge clk or negedge reset) begin
         if (!reset) begin
            ack <= 1'b0; rd <= '0; cnt <= '0; ph <= 0; wc <= 0;
         end else begin
            case (ph)
               0: if (req) begin
                     if (wc == 1) begin ack <= 1'b1; ph <= 1; end
                     wc <= wc + 1;
                  end
               1: begin rd <= cnt; ph <= 2; end
               2: begin ack <= 1'b0; cnt <= cnt + 1; ph <= 3; end
               default: begin wc <= 0; ph <= 0; end
            endcase
         end
      end
   end

   assign s0_ack   = g_slv[0].ack;
   assign s0_rdata = g_slv[0].rd;
   assign s1_ack   = g_slv[1].ack;
   assign s1_rdata = g_slv[1].rd;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   // Scoreboard: every ack must match a queued expectation.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (m0_ack) begin
            chk("m0 ack expected", 32'(exp0.size() > 0), 32'd1);
            if (exp0.size() > 0) chk("m0 rdata", m0_rdata, exp0.pop_front());
         end
         if (m1_ack) begin
            chk("m1 ack expected", 32'(exp1.size() > 0), 32'd1);
            if (exp1.size() > 0) chk("m1 rdata", m1_rdata, exp1.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_tr();
      tr_s0 = '0; tr_s1 = '0; tr_a0 = '0; tr_a1 = '0;
      acks0 = 0; acks1 = 0; lim0 = 1; lim1 = 1;
      fwd1_n = 0; fwd1_bad = 0;
   endtask

   task automatic run(input int from, input int to);
      for (int k = from; k <= to; k++) begin
         tick();
         tr_s0[k] = s0_req; tr_s1[k] = s1_req;
         tr_a0[k] = m0_ack; tr_a1[k] = m1_ack;
         if (s1_req) begin
            fwd1_n++;
            if (!(s1_cmd === 1'b1 && s1_wdata === 32'hDEAD_BEEF))
               fwd1_bad++;
         end
         if (m0_ack) begin acks0++; if (acks0 >= lim0) m0_req = 1'b0; end
         if (m1_ack) begin acks1++; if (acks1 >= lim1) m1_req = 1'b0; end
      end
   endtask

   task automatic idle_masters();
      m0_req = 0; m0_cmd = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_cmd = 0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic do_reset();
      idle_masters();
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      clr_tr();
   endtask

   initial begin
      idle_masters();
      clr_tr();
      reset = 1'b0;
      tick(); tick();
      chk("rst s0_req", 32'(s0_req), 0);
      chk("rst s1_req", 32'(s1_req), 0);
      chk("rst m0_ack", 32'(m0_ack), 0);
      chk("rst m1_ack", 32'(m1_ack), 0);
      chk("rst m0_rdata", m0_rdata, 0);
      chk("rst m1_rdata", m1_rdata, 0);
      chk("rst s0_addr", s0_addr, 0);
      reset = 1'b1;
      tick();

      // single read
      do_reset();
      m0_req = 1; m0_addr = 32'h0000_0010;
      exp0.push_back(32'h0);
      run(1, 8);
      chk("single s0_req", tr_s0, 32'h0000_000E);
      chk("single m0_ack", tr_a0, 32'h0000_0040);
      chk("single m1_ack", tr_a1, 32'h0);

      // contention on s0
      do_reset();
      m0_req = 1; m0_addr = 32'h0000_0004;
      m1_req = 1; m1_addr = 32'h0000_0004;
      exp0.push_back(32'h0);
      exp1.push_back(32'h1);
      run(1, 14);
      chk("cont s0_req", tr_s0, 32'h0000_038E);
      chk("cont m0_ack", tr_a0, 32'h0000_0040);
      chk("cont m1_ack", tr_a1, 32'h0000_1000);

      // parallel to s0 and s1
      do_reset();
      m0_req = 1; m0_addr = 32'h0000_0000;
      m1_req = 1; m1_addr = 32'h8000_0000;
      exp0.push_back(32'h0);
      exp1.push_back(32'h0);
      run(1, 2);
      chk("par s0_addr", s0_addr, 32'h0000_0000);
      chk("par s1_addr", s1_addr, 32'h8000_0000);
      chk("par reqs", {30'd0, s1_req, s0_req}, 32'h3);
      run(3, 8);
      chk("par m0_ack", tr_a0, 32'h0000_0040);
      chk("par m1_ack", tr_a1, 32'h0000_0040);

      // write forwarding on s1
      do_reset();
      m1_req = 1; m1_cmd = 1;
      m1_addr = 32'h8000_0020; m1_wdata = 32'hDEAD_BEEF;
      exp1.push_back(32'h0);
      run(1, 9);
      chk("wr fwd cycles", fwd1_n, 3);
      chk("wr fwd bus", fwd1_bad, 0);
      chk("wr m1_ack", tr_a1, 32'h0000_0040);
      chk("wr s0_req", tr_s0, 32'h0);

      // sustained request, three transactions
      do_reset();
      lim0 = 3;
      m0_req = 1; m0_addr = 32'h0000_0010;
      exp0.push_back(32'h0);
      exp0.push_back(32'h1);
      exp0.push_back(32'h2);
      run(1, 24);
      chk("sus s0_req", tr_s0, 32'h0003_870E);
      chk("sus m0_ack", tr_a0, 32'h0010_2040);
      chk("sus m0_rdata", m0_rdata, 32'h2);

      // reset in cycle 2 of a transaction
      clr_tr();
      m0_req = 1; m0_addr = 32'h0000_0010;
      run(1, 2);
      chk("mid s0_req before", 32'(s0_req), 1);
      reset = 1'b0;
      #1;
      chk("mid s0_req", 32'(s0_req), 0);
      chk("mid m0_ack", 32'(m0_ack), 0);
      chk("mid m0_rdata", m0_rdata, 0);
      m0_req = 0;
      tick();
      reset = 1'b1;
      tick();
      clr_tr();
      m0_req = 1; m0_addr = 32'h0000_0004;
      m1_req = 1; m1_addr = 32'h0000_0004;
      exp0.push_back(32'h0);
      exp1.push_back(32'h1);
      run(1, 14);
      chk("post rst m0 wins", tr_a0, 32'h0000_0040);
      chk("post rst m1_ack", tr_a1, 32'h0000_1000);

      tick(); tick();
      chk("sb0 drained", exp0.size(), 0);
      chk("sb1 drained", exp1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
